carry_output_scheduler: RTL and testbench
=========================================

# carry_output_scheduler

Output scheduler behind the carry-propagation stage of the AV1 arithmetic encoder. Each cycle it selects the byte group from either the main carry-propagation block or the auxiliar carry-propagation block and writes 0–3 bytes in order into a byte FIFO. It drains the FIFO one byte per cycle to the bitstream writer over a valid/ready handshake, back-pressures the encoder pipeline, and sequences the end-of-frame flush.

## Interface
- OUTPUT_WIDTH, 8, byte width
- FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH (16)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- in_main_flag  in  2  main block byte count: 01 = 1 byte, 11 = 2 bytes, 00/10 = none
- in_main_bit_1, in_main_bit_2  in  OUTPUT_WIDTH  main bytes, bit_1 first
- in_aux_flag  in  3  auxiliar byte count: 001 = 1, 011 = 2, 010 = 3, others = none
- in_aux_bit_1..in_aux_bit_3  in  OUTPUT_WIDTH  auxiliar bytes, bit_1 first
- in_ctrl_mux_final  in  1  1 = take auxiliar group, 0 = take main group
- in_final_flag  in  1  last symbol of frame this cycle
- in_ready  in  1  downstream accepts out_byte
- out_byte  out  OUTPUT_WIDTH  FIFO head
- out_valid  out  1  FIFO non-empty
- out_stall  out  1  upstream must hold; inputs ignored
- out_fifo_level  out  FIFO_ADDR_WIDTH+1  bytes stored
- out_flush_done  out  1  one-cycle pulse, frame fully drained
- out_overflow  out  1  sticky error

## Operation
- Source select: in_ctrl_mux_final picks exactly one group each cycle. The unselected group is discarded.
- Byte count n: decoded from the selected flag (0–3). Bytes are written at wr_ptr, wr_ptr+1, wr_ptr+2 in bit_1, bit_2, bit_3 order. wr_ptr advances by n.
- Read: when out_valid && in_ready, the head byte is consumed and rd_ptr advances by 1.
- Wrap: pointers are FIFO_ADDR_WIDTH bits and wrap mod depth. A multi-byte write may straddle the wrap (e.g. wr_ptr=15, n=3 writes entries 15, 0, 1).
- Level: level_next = level + n_accepted − (out_valid && in_ready). Simultaneous write and read are both honoured.
- out_stall = (state != RUN) || (depth − level < 3). It is combinational from registered state/level only, so an accepted write never overflows.
- Write while out_stall=1 with n>0: bytes dropped, FIFO unchanged, out_overflow ← 1. It clears only on reset.
- State machine:
  - RUN: accepts input.
    - in_final_flag=1 && !out_stall: that cycle's bytes are accepted, then → FLUSH.
    - in_final_flag=1 while stalled: flag ignored. Upstream holds and re-presents it.
  - FLUSH: no input accepted; FIFO drains. When level==0 → DONE.
  - DONE: out_flush_done=1 for this cycle only, out_stall=1; → RUN next cycle.
- Reset mid-operation (any state): pointers and level cleared, FIFO contents discarded, state=RUN, out_overflow=0. Memory contents need not be reset.

## Timing
- Reset values: out_valid=0, out_stall=0, out_fifo_level=0, out_flush_done=0, out_overflow=0, out_byte=don't-care (bench ignores it while out_valid=0).
- Write-to-output latency: a byte written at edge t is visible on out_byte with out_valid=1 in the cycle after t. FIFO is first-word fall-through.
- Throughput: 1 byte/cycle out; up to 3 bytes/cycle in. The stall threshold leaves headroom for a 3-byte group.
- Full: level=16 → out_stall=1, out_valid=1. Empty: level=0 → out_valid=0 and out_byte ignored.
- FLUSH with level already 0: FLUSH lasts 1 cycle, then DONE.
- in_ready is sampled only while out_valid=1. in_ready=1 on an empty FIFO has no effect.

## Test plan
- Reset, then main flag 11 with bytes 0x12,0x34, in_ready=1: out_byte 0x12 the next cycle, 0x34 the cycle after; level goes 0→2→1→0.
- in_ctrl_mux_final=1, aux 010 with 0xFE,0x00,0x00, main 11 with 0xAA,0xBB: only 0xFE,0x00,0x00 appear; 0xAA,0xBB never appear.
- in_ready=0, feed main 11 groups until level=14: out_stall rises at level 14. One 2-byte write while stalled → out_overflow=1, level stays 14. Raise in_ready: 14 bytes drain in order, out_overflow stays 1.
- Wrap: bring wr_ptr to 15, then write aux 3 bytes 0x01,0x02,0x03: read order preserved across the wrap, level correct.
- Simultaneous: level=1, write 1 byte and read 1 byte in the same cycle → level stays 1.
- Flush: final flag with main 01 byte 0x55 and 2 bytes queued:
  - FLUSH state, out_stall=1, inputs ignored.
  - 3 bytes drain.
  - out_flush_done pulses exactly one cycle after level reaches 0, then out_stall=0.
  - Assert reset during FLUSH → level=0 and state RUN on the next cycle.

Source files
------------

// File: rtl/carry_output_scheduler.sv
// Output scheduler for the AV1 arithmetic-encoder carry stage: merges the main or auxiliar
// byte group (0-3 bytes) into a first-word-fall-through byte FIFO and sequences the end-of-frame flush.
module carry_output_scheduler #(
  parameter int OUTPUT_WIDTH    = 8,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 in_main_flag,
  input  logic [OUTPUT_WIDTH-1:0]    in_main_bit_1,
  input  logic [OUTPUT_WIDTH-1:0]    in_main_bit_2,
  input  logic [2:0]                 in_aux_flag,
  input  logic [OUTPUT_WIDTH-1:0]    in_aux_bit_1,
  input  logic [OUTPUT_WIDTH-1:0]    in_aux_bit_2,
  input  logic [OUTPUT_WIDTH-1:0]    in_aux_bit_3,
  input  logic                       in_ctrl_mux_final,
  input  logic                       in_final_flag,
  input  logic                       in_ready,
  output logic [OUTPUT_WIDTH-1:0]    out_byte,
  output logic                       out_valid,
  output logic                       out_stall,
  output logic [FIFO_ADDR_WIDTH:0]   out_fifo_level,
  output logic                       out_flush_done,
  output logic                       out_overflow,
  output logic [1:0]                 out_dbg_state
);

  // Handshake: a byte moves downstream on any clock edge where out_valid && in_ready;
  // upstream groups are taken only on edges where out_stall was low, otherwise dropped.

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int LW    = FIFO_ADDR_WIDTH + 1;
  // Stall once fewer than three free slots remain so a 3-byte group always fits.
  localparam logic [LW-1:0] STALL_LEVEL = LW'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                level_q, level_d;
  logic                         overflow_q, overflow_d;
  logic [OUTPUT_WIDTH-1:0]      mem_q [DEPTH];

  logic [1:0]                   grp_cnt;
  logic [OUTPUT_WIDTH-1:0]      grp_byte [3];
  logic                         stall;
  logic                         rd_fire;
  logic                         wr_fire;
  logic [1:0]                   wr_cnt;

  always_comb begin
    grp_cnt     = 2'd0;
    grp_byte[0] = in_main_bit_1;
    grp_byte[1] = in_main_bit_2;
    grp_byte[2] = '0;
    if (in_ctrl_mux_final) begin
      grp_byte[0] = in_aux_bit_1;
      grp_byte[1] = in_aux_bit_2;
      grp_byte[2] = in_aux_bit_3;
      case (in_aux_flag)
        3'b001:  grp_cnt = 2'd1;
        3'b011:  grp_cnt = 2'd2;
        3'b010:  grp_cnt = 2'd3;
        default: grp_cnt = 2'd0;
      endcase
    end else begin
      case (in_main_flag)
        2'b01:   grp_cnt = 2'd1;
        2'b11:   grp_cnt = 2'd2;
        default: grp_cnt = 2'd0;
      endcase
    end
  end

  always_comb begin
    stall      = (state_q != ST_RUN) || (level_q >= STALL_LEVEL);
    rd_fire    = (level_q != '0) && in_ready;
    wr_fire    = !stall && (grp_cnt != 2'd0);
    wr_cnt     = wr_fire ? grp_cnt : 2'd0;

    wr_ptr_d   = wr_ptr_q + FIFO_ADDR_WIDTH'(wr_cnt);
    rd_ptr_d   = rd_ptr_q + FIFO_ADDR_WIDTH'(rd_fire);
    level_d    = level_q + LW'(wr_cnt) - LW'(rd_fire);
    overflow_d = overflow_q | (stall && (grp_cnt != 2'd0));

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (in_final_flag && !stall) state_d = ST_FLUSH;
      ST_FLUSH: if (level_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < grp_cnt) begin
          mem_q[wr_ptr_q + FIFO_ADDR_WIDTH'(k)] <= grp_byte[k];
        end
      end
    end
  end

  assign out_byte       = mem_q[rd_ptr_q];
  assign out_valid      = (level_q != '0);
  assign out_stall      = stall;
  assign out_fifo_level = level_q;
  assign out_flush_done = (state_q == ST_DONE);
  assign out_overflow   = overflow_q;
  assign out_dbg_state  = state_q;

endmodule

// File: tb/tb_carry_output_scheduler.sv
// Bench for carry_output_scheduler: directed scenarios plus random traffic, all outputs
// compared each cycle against a byte-queue reference model.
module tb_carry_output_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] in_main_flag = '0;
  logic [7:0] in_main_bit_1 = '0, in_main_bit_2 = '0;
  logic [2:0] in_aux_flag = '0;
  logic [7:0] in_aux_bit_1 = '0, in_aux_bit_2 = '0, in_aux_bit_3 = '0;
  logic       in_ctrl_mux_final = 1'b0;
  logic       in_final_flag = 1'b0;
  logic       in_ready = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_stall;
  logic [4:0] out_fifo_level;
  logic       out_flush_done;
  logic       out_overflow;
  logic [1:0] out_dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  carry_output_scheduler #(.OUTPUT_WIDTH(8), .FIFO_ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_main_flag(in_main_flag), .in_main_bit_1(in_main_bit_1), .in_main_bit_2(in_main_bit_2),
    .in_aux_flag(in_aux_flag), .in_aux_bit_1(in_aux_bit_1), .in_aux_bit_2(in_aux_bit_2),
    .in_aux_bit_3(in_aux_bit_3), .in_ctrl_mux_final(in_ctrl_mux_final),
    .in_final_flag(in_final_flag), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_stall(out_stall),
    .out_fifo_level(out_fifo_level), .out_flush_done(out_flush_done),
    .out_overflow(out_overflow), .out_dbg_state(out_dbg_state)
  );

  // scoreboard: bytes the FIFO should hold, oldest first
  logic [7:0] exp_q[$];
  int         mode;      // 0 = accepting, 1 = flushing, 2 = flush-done cycle
  logic       exp_ovf;
  logic       known;
  int         n_vec;
  int         n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic model_stall();
    return (mode != 0) || (16 - exp_q.size() < 3);
  endfunction

  task automatic check_outputs();
    check_val("level", 32'(out_fifo_level), 32'(exp_q.size()));
    check_val("valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_val("stall", 32'(out_stall), 32'(model_stall()));
    check_val("flush_done", 32'(out_flush_done), 32'(mode == 2));
    check_val("overflow", 32'(out_overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) check_val("byte", 32'(out_byte), 32'(exp_q[0]));
  endtask

  // driver: one clock cycle; checks the current state, then applies inputs and advances the model
  task automatic step(input logic rst, input logic [1:0] mf, input logic [7:0] m1, input logic [7:0] m2,
                      input logic [2:0] af, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] a3, input logic mux, input logic fin, input logic rdy);
    logic [7:0] grp[$];
    int         old_size;
    logic       stl;
    @(negedge clk);
    if (known) check_outputs();
    reset = rst;
    in_main_flag = mf; in_main_bit_1 = m1; in_main_bit_2 = m2;
    in_aux_flag = af; in_aux_bit_1 = a1; in_aux_bit_2 = a2; in_aux_bit_3 = a3;
    in_ctrl_mux_final = mux; in_final_flag = fin; in_ready = rdy;
    if (rst) begin
      exp_q.delete();
      mode = 0;
      exp_ovf = 1'b0;
      known = 1'b1;
      return;
    end
    if (mux) begin
      if (af == 3'b001) grp = '{a1};
      else if (af == 3'b011) grp = '{a1, a2};
      else if (af == 3'b010) grp = '{a1, a2, a3};
    end else begin
      if (mf == 2'b01) grp = '{m1};
      else if (mf == 2'b11) grp = '{m1, m2};
    end
    stl = model_stall();
    old_size = exp_q.size();
    if (grp.size() != 0 && stl) exp_ovf = 1'b1;
    if (old_size != 0 && rdy) void'(exp_q.pop_front());
    if (!stl) foreach (grp[i]) exp_q.push_back(grp[i]);
    case (mode)
      0: if (fin && !stl) mode = 1;
      1: if (old_size == 0) mode = 2;
      default: mode = 0;
    endcase
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic main_wr(input logic [1:0] mf, input logic [7:0] m1, input logic [7:0] m2, input logic rdy);
    step(1'b0, mf, m1, m2, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    n_vec = 0; n_err = 0; known = 1'b0; mode = 0; exp_ovf = 1'b0;
    do_reset();
    idle(1, 1'b0);

    // two main bytes streamed straight out
    main_wr(2'b11, 8'h12, 8'h34, 1'b1);
    idle(4, 1'b1);

    // aux group selected, main group must be discarded
    step(1'b0, 2'b11, 8'hAA, 8'hBB, 3'b010, 8'hFE, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);

    // fill to the stall threshold, overflow with one stalled write, then drain
    for (int i = 0; i < 7; i++) main_wr(2'b11, 8'(2 * i + 1), 8'(2 * i + 2), 1'b0);
    main_wr(2'b11, 8'hEE, 8'hEF, 1'b0);
    idle(2, 1'b0);
    idle(18, 1'b1);

    // wrap: bring wr_ptr to 15 then write three bytes straddling the wrap
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b0, 2'b00, 8'h00, 8'h00, 3'b010, 8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3), 1'b1, 1'b0, 1'b1);
    step(1'b0, 2'b00, 8'h00, 8'h00, 3'b010, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 1'b1);
    idle(16, 1'b1);

    // simultaneous read and write at level 1
    main_wr(2'b01, 8'h77, 8'h00, 1'b0);
    main_wr(2'b01, 8'h78, 8'h00, 1'b1);
    idle(3, 1'b1);

    // flush with two bytes queued plus the final byte
    main_wr(2'b11, 8'h21, 8'h22, 1'b0);
    step(1'b0, 2'b01, 8'h55, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);

    // flush from an empty FIFO, then reset in the middle of a second flush
    step(1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    main_wr(2'b11, 8'h31, 8'h32, 1'b0);
    step(1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 499) == 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0));
    end
    idle(24, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
